// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter
//   Shares the instruction SRAM banks (32 bits x 512 rows each, 1-cycle read)
//   between processor fetch (RUN) and the program loader (LOAD).
//   A halfword address splits into bank = a[12:10], row = a[9:1], half = a[0].
//   Mode changes pass through one idle cycle in each direction:
//   RUN -> DRAIN -> LOAD -> SWITCH -> RUN.
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   load_mode           level: 1 = loader owns the memory, processor stalled
//   ld_valid/ld_ready   loader write handshake; ld_addr/ld_data = halfword write
//   ld_done             1-cycle pulse when LOAD is left
//   cpu_req/cpu_addr    fetch request; cpu_stall = fetch not accepted
//   cpu_instr/cpu_valid fetch result, one cycle after acceptance
//   mem_*               bank controls (per-bank csb, shared web/wmask/addr/wdata)
//   mem_rdata           bank read data, bank k at [32k+31:32k]
module instr_mem_arbiter #(
    parameter int BANKS  = 8,
    parameter int ADDR_W = 13,
    parameter int ROW_W  = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_mode,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic              ld_done,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    output logic [15:0]       cpu_instr,
    output logic              cpu_valid,
    output logic [7:0]        mem_csb,
    output logic              mem_web,
    output logic [3:0]        mem_wmask,
    output logic [ROW_W-1:0]  mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [255:0]      mem_rdata
);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD, SWITCH} state_t;

    // One bit per bank number that is actually populated.
    localparam logic [8:0] BANK_LIMIT   = 9'(1) << BANKS;
    localparam logic [7:0] BANK_PRESENT = 8'(BANK_LIMIT - 9'd1);

    state_t      state_q, state_d;
    logic        fetch_go;
    logic        rd_pend_q;
    logic [2:0]  rd_bank_q;
    logic        rd_half_q;
    logic        rd_oob_q;
    logic [15:0] instr_hold_q;
    logic [31:0] rd_word;
    logic [15:0] rd_half_data;

    logic [2:0] cpu_bank, ld_bank;
    assign cpu_bank = cpu_addr[ADDR_W-1 -: 3];
    assign ld_bank  = ld_addr[ADDR_W-1 -: 3];

    // Bank controls are decoded from the current-cycle request; the SRAMs
    // register them on clk. Everything is forced idle while reset is held so
    // no access leaks out during an asynchronous reset.
    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        cpu_stall = 1'b0;
        fetch_go  = 1'b0;
        mem_csb   = '1;
        mem_web   = 1'b1;
        mem_wmask = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset_n) begin
            case (state_q)
                RUN: begin
                    if (load_mode) begin
                        cpu_stall = 1'b1;
                        state_d   = DRAIN;
                    end else if (cpu_req) begin
                        fetch_go = 1'b1;
                        mem_addr = cpu_addr[ROW_W:1];
                        if (BANK_PRESENT[cpu_bank]) mem_csb[cpu_bank] = 1'b0;
                    end
                end
                DRAIN: begin
                    cpu_stall = 1'b1;
                    state_d   = LOAD;
                end
                LOAD: begin
                    cpu_stall = 1'b1;
                    if (!load_mode) begin
                        state_d = SWITCH;
                    end else begin
                        ld_ready = 1'b1;
                        if (ld_valid) begin
                            mem_web   = 1'b0;
                            mem_wmask = ld_addr[0] ? 4'b1100 : 4'b0011;
                            mem_addr  = ld_addr[ROW_W:1];
                            mem_wdata = ld_data;
                            // Out-of-range writes complete the handshake but touch no bank.
                            if (BANK_PRESENT[ld_bank]) mem_csb[ld_bank] = 1'b0;
                        end
                    end
                end
                SWITCH: begin
                    ld_done   = 1'b1;
                    cpu_stall = 1'b1;
                    state_d   = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            rd_pend_q    <= 1'b0;
            rd_bank_q    <= '0;
            rd_half_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
            instr_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= fetch_go;
            instr_hold_q <= cpu_instr;
            if (fetch_go) begin
                rd_bank_q <= cpu_bank;
                rd_half_q <= cpu_addr[0];
                rd_oob_q  <= ~BANK_PRESENT[cpu_bank];
            end
        end
    end

    // Return path: select the bank and half captured with the request.
    always_comb begin
        rd_word      = mem_rdata[{rd_bank_q, 5'b0} +: 32];
        rd_half_data = rd_half_q ? rd_word[31:16] : rd_word[15:0];
    end

    assign cpu_valid = rd_pend_q;
    assign cpu_instr = rd_pend_q ? (rd_oob_q ? 16'h0000 : rd_half_data) : instr_hold_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: an 8-bank and a 4-bank instance share one
// stimulus stream; each has its own behavioural SRAM bank model. Expected
// fetch data comes from a halfword-addressed reference memory.
module tb_instr_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n, load_mode, ld_valid, cpu_req;
    logic [12:0] ld_addr, cpu_addr;
    logic [15:0] ld_data;

    logic        ld_ready8, ld_done8, cpu_stall8, cpu_valid8, web8;
    logic [15:0] cpu_instr8, wdata8;
    logic [7:0]  csb8;
    logic [3:0]  wmask8;
    logic [8:0]  maddr8;
    logic [255:0] rdata8;

    logic        ld_ready4, ld_done4, cpu_stall4, cpu_valid4, web4;
    logic [15:0] cpu_instr4, wdata4;
    logic [7:0]  csb4;
    logic [3:0]  wmask4;
    logic [8:0]  maddr4;
    logic [255:0] rdata4;

    instr_mem_arbiter #(.BANKS(8), .ADDR_W(13), .ROW_W(9)) dut8 (
        .clk(clk), .reset_n(reset_n), .load_mode(load_mode), .ld_valid(ld_valid),
        .ld_ready(ld_ready8), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done8),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall8),
        .cpu_instr(cpu_instr8), .cpu_valid(cpu_valid8), .mem_csb(csb8), .mem_web(web8),
        .mem_wmask(wmask8), .mem_addr(maddr8), .mem_wdata(wdata8), .mem_rdata(rdata8)
    );

    instr_mem_arbiter #(.BANKS(4), .ADDR_W(13), .ROW_W(9)) dut4 (
        .clk(clk), .reset_n(reset_n), .load_mode(load_mode), .ld_valid(ld_valid),
        .ld_ready(ld_ready4), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done4),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall4),
        .cpu_instr(cpu_instr4), .cpu_valid(cpu_valid4), .mem_csb(csb4), .mem_web(web4),
        .mem_wmask(wmask4), .mem_addr(maddr4), .mem_wdata(wdata4), .mem_rdata(rdata4)
    );

    initial forever #5 clk = ~clk;

    // ---------------- SRAM bank models (wrapper duplicates wdata) ----------
    logic [31:0] sram8 [8][512];
    logic [31:0] dout8 [8];
    logic [31:0] wd32_8;
    logic [31:0] sram4 [8][512];
    logic [31:0] dout4 [8];
    logic [31:0] wd32_4;

    always_comb begin
        wd32_8 = {wdata8, wdata8};
        wd32_4 = {wdata4, wdata4};
        rdata8 = '0;
        rdata4 = '0;
        for (int k = 0; k < 8; k++) begin
            rdata8[32*k +: 32] = dout8[k];
            rdata4[32*k +: 32] = dout4[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (!csb8[k]) begin
                if (!web8) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask8[b]) sram8[k][maddr8][8*b +: 8] <= wd32_8[8*b +: 8];
                end else begin
                    dout8[k] <= sram8[k][maddr8];
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (!csb4[k]) begin
                if (!web4) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask4[b]) sram4[k][maddr4][8*b +: 8] <= wd32_4[8*b +: 8];
                end else begin
                    dout4[k] <= sram4[k][maddr4];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];
    logic [12:0] written [$];
    int          total = 0;
    int          bad   = 0;
    logic        exp_v8, exp_v4;
    logic [15:0] exp_i8, exp_i4;

    function automatic logic [7:0] exp_csb(input int banks, input logic [12:0] a);
        int bank;
        bank = int'(a) / 1024;
        if (bank < banks) return ~(8'(1) << bank);
        return 8'hFF;
    endfunction

    function automatic logic [15:0] exp_data(input int banks, input logic [12:0] a);
        if (int'(a) / 1024 >= banks) return 16'h0000;
        return ref_mem[int'(a)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then check the fetch return path of both instances.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("valid8", 32'(cpu_valid8), 32'(exp_v8));
        chk("instr8", 32'(cpu_instr8), 32'(exp_i8));
        chk("valid4", 32'(cpu_valid4), 32'(exp_v4));
        chk("instr4", 32'(cpu_instr4), 32'(exp_i4));
        exp_v8 = 1'b0;
        exp_v4 = 1'b0;
    endtask

    task automatic issue_fetch(input logic [12:0] a);
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        chk("stall_run", 32'(cpu_stall8), 32'd0);
        chk("csb_rd8", 32'(csb8), 32'(exp_csb(8, a)));
        chk("csb_rd4", 32'(csb4), 32'(exp_csb(4, a)));
        chk("web_rd", 32'(web8), 32'd1);
        exp_v8 = 1'b1; exp_i8 = exp_data(8, a);
        exp_v4 = 1'b1; exp_i4 = exp_data(4, a);
    endtask

    task automatic do_write(input logic [12:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        cpu_req  = 1'b1;                 // must be ignored in LOAD
        cpu_addr = 13'($urandom);
        #1;
        chk("ld_ready", 32'(ld_ready8), 32'd1);
        chk("stall_ld", 32'(cpu_stall8), 32'd1);
        chk("csb_wr8", 32'(csb8), 32'(exp_csb(8, a)));
        chk("csb_wr4", 32'(csb4), 32'(exp_csb(4, a)));
        chk("web_wr", 32'(web8), 32'd0);
        chk("wmask", 32'(wmask8), a[0] ? 32'hC : 32'h3);
        chk("wdata", 32'(wdata8), 32'(d));
        chk("waddr", 32'(maddr8), 32'(a[9:1]));
        ref_mem[int'(a)] = d;
        written.push_back(a);
        tick();
    endtask

    // From RUN: raise load_mode, pass DRAIN, arrive in LOAD.
    task automatic enter_load(input logic with_req);
        load_mode = 1'b1;
        cpu_req   = with_req;
        cpu_addr  = 13'h0000;
        #1;
        chk("stall_lm", 32'(cpu_stall8), 32'd1);
        chk("csb_lm", 32'(csb8), 32'hFF);
        tick();
        cpu_req = 1'b0;
        #1;
        chk("drain_ready", 32'(ld_ready8), 32'd0);
        chk("drain_csb", 32'(csb8), 32'hFF);
        chk("drain_stall", 32'(cpu_stall8), 32'd1);
        tick();
    endtask

    // From LOAD: drop load_mode with ld_valid still high; the write must not land.
    task automatic exit_load();
        load_mode = 1'b0;
        ld_valid  = 1'b1;
        ld_addr   = 13'h0000;
        ld_data   = 16'hFFFF;
        cpu_req   = 1'b0;
        #1;
        chk("exit_csb8", 32'(csb8), 32'hFF);
        chk("exit_csb4", 32'(csb4), 32'hFF);
        chk("exit_ready", 32'(ld_ready8), 32'd0);
        chk("exit_done", 32'(ld_done8), 32'd0);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("sw_done8", 32'(ld_done8), 32'd1);
        chk("sw_done4", 32'(ld_done4), 32'd1);
        chk("sw_stall", 32'(cpu_stall8), 32'd1);
        chk("sw_csb", 32'(csb8), 32'hFF);
        tick();
        #1;
        chk("run_done", 32'(ld_done8), 32'd0);
        chk("run_stall8", 32'(cpu_stall8), 32'd0);
        chk("run_stall4", 32'(cpu_stall4), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; load_mode = 1'b0; ld_valid = 1'b0; cpu_req = 1'b0;
        ld_addr = '0; ld_data = '0; cpu_addr = '0;
        exp_v8 = 1'b0; exp_v4 = 1'b0; exp_i8 = '0; exp_i4 = '0;

        #3;
        chk("rst_ready", 32'(ld_ready8), 32'd0);
        chk("rst_done", 32'(ld_done8), 32'd0);
        chk("rst_valid", 32'(cpu_valid8), 32'd0);
        chk("rst_instr", 32'(cpu_instr8), 32'd0);
        chk("rst_csb8", 32'(csb8), 32'hFF);
        chk("rst_csb4", 32'(csb4), 32'hFF);
        chk("rst_web", 32'(web8), 32'd1);
        chk("rst_wmask", 32'(wmask8), 32'd0);
        chk("rst_addr", 32'(maddr8), 32'd0);
        chk("rst_wdata", 32'(wdata8), 32'd0);

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Load phase with fixed and random writes
        enter_load(1'b0);
        #1;
        chk("load_ready4", 32'(ld_ready4), 32'd1);
        do_write(13'h0000, 16'hA5A5);
        do_write(13'h0001, 16'h3C3C);
        do_write(13'h1FFF, 16'hBEEF);
        do_write(13'h0400, 16'($urandom));
        do_write(13'h0401, 16'($urandom));
        do_write(13'h0800, 16'($urandom));
        do_write(13'h1000, 16'h1234);
        for (int i = 0; i < 16; i++) do_write(13'($urandom), 16'($urandom));
        exit_load();

        // Fixed fetches, then back-to-back across banks 1 and 2, then out of range for BANKS=4
        issue_fetch(13'h0000); tick();
        issue_fetch(13'h0001); tick();
        issue_fetch(13'h1FFF); tick();
        issue_fetch(13'h0400); tick();
        issue_fetch(13'h0401); tick();
        issue_fetch(13'h0800); tick();
        issue_fetch(13'h1000); tick();
        cpu_req = 1'b0; tick();

        // Random fetch traffic over written addresses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) issue_fetch(written[$urandom_range(0, written.size() - 1)]);
            else cpu_req = 1'b0;
            tick();
        end

        // Mode switch with a fetch in flight and cpu_req rising with load_mode
        issue_fetch(13'h0001);
        tick();
        enter_load(1'b1);
        do_write(13'h0000, 16'h5A5A);
        ld_valid = 1'b0; cpu_req = 1'b1; cpu_addr = 13'h0001;
        #1;
        chk("load_idle_csb", 32'(csb8), 32'hFF);
        tick();
        exit_load();
        issue_fetch(13'h0000); tick();

        // Reset in the middle of a fetch
        issue_fetch(13'h0001);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_csb", 32'(csb8), 32'hFF);
        chk("mid_rst_valid", 32'(cpu_valid8), 32'd0);
        chk("mid_rst_instr", 32'(cpu_instr8), 32'd0);
        chk("mid_rst_web", 32'(web8), 32'd1);
        exp_v8 = 1'b0; exp_v4 = 1'b0; exp_i8 = '0; exp_i4 = '0;
        tick();
        reset_n = 1'b1;
        issue_fetch(13'h1FFF); tick();
        issue_fetch(13'h0000); tick();
        cpu_req = 1'b0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
